// File: rtl/pc_npc_sequencer.sv
// PC/nPC pair with SPARC-style delayed control transfer, delay-slot annul, link and alignment status.
// Optional: define NPC_MISALIGN_TRAP_EN to redirect misaligned taken transfers to TRAP_VECTOR.
module pc_npc_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'('h80)
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              stall,
  input  logic              xfer_valid,
  input  logic [1:0]        xfer_kind,
  input  logic              cond_true,
  input  logic              is_ba,
  input  logic              annul_a,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nPC,
  output logic              fetch_valid,
  output logic              annul_slot,
  output logic [ADDR_W-1:0] link_addr,
  output logic              align_err
);

  typedef enum logic {S_BOOT, S_RUN} state_e;
  typedef enum logic [1:0] {K_BRANCH = 2'b00, K_CALL = 2'b01, K_JMPL = 2'b10, K_RSVD = 2'b11} kind_e;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d, link_q, link_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              annul_q, annul_d;
  logic              align_err_q, align_err_d;

  logic advance, accept, is_branch, taken, branch_annul;

  // An annulled delay slot is a NOP, so it cannot redirect the stream.
  assign advance      = (state_q == S_RUN) && !stall;
  assign accept       = advance && xfer_valid && (xfer_kind != K_RSVD) && !annul_q;
  assign is_branch    = (xfer_kind == K_BRANCH);
  assign taken        = accept && (!is_branch || is_ba || cond_true);
  assign branch_annul = accept && is_branch && annul_a && (is_ba || !cond_true);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    link_d        = link_q;
    annul_d       = annul_q;
    fetch_valid_d = fetch_valid_q;
    align_err_d   = align_err_q;
    case (state_q)
      S_BOOT: begin
        state_d       = S_RUN;
        fetch_valid_d = 1'b1;
      end
      S_RUN: begin
        if (advance) begin
          pc_d    = npc_q;
          npc_d   = npc_q + STEP;
          annul_d = branch_annul;
          if (accept && !is_branch) link_d = pc_q - STEP;
          if (taken) npc_d = {target[ADDR_W-1:2], 2'b00};
`ifdef NPC_MISALIGN_TRAP_EN
          if (taken && (target[1:0] != 2'b00)) begin
            npc_d       = TRAP_VECTOR;
            align_err_d = 1'b1;
            annul_d     = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

`ifndef NPC_MISALIGN_TRAP_EN
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{target[1:0], TRAP_VECTOR};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + STEP;
      link_q        <= '0;
      annul_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      link_q        <= link_d;
      annul_q       <= annul_d;
      fetch_valid_q <= fetch_valid_d;
      align_err_q   <= align_err_d;
    end
  end

  assign PC          = pc_q;
  assign nPC         = npc_q;
  assign link_addr   = link_q;
  assign annul_slot  = annul_q;
  assign fetch_valid = fetch_valid_q;
  assign align_err   = align_err_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Randomized + directed bench for pc_npc_sequencer; a 32-bit and an 8-bit instance share one
// 32-bit reference model (8-bit results are the low byte of the modulo-2^32 model).
module tb_pc_npc_sequencer;

  logic        Clk = 1'b0;
  logic        R = 1'b0;
  logic        stall = 1'b0, xfer_valid = 1'b0, cond_true = 1'b0, is_ba = 1'b0, annul_a = 1'b0;
  logic [1:0]  xfer_kind = 2'b00;
  logic [31:0] target = '0;

  logic [31:0] pc32, npc32, link32;
  logic        fv32, an32, ae32;
  logic [7:0]  pc8, npc8, link8;
  logic        fv8, an8, ae8;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural view of the fetch stream.
  logic [31:0] m_pc, m_npc, m_link;
  logic        m_run, m_annul, m_align;

  pc_npc_sequencer #(.ADDR_W(32)) dut32 (
    .Clk(Clk), .R(R), .stall(stall), .xfer_valid(xfer_valid), .xfer_kind(xfer_kind),
    .cond_true(cond_true), .is_ba(is_ba), .annul_a(annul_a), .target(target),
    .PC(pc32), .nPC(npc32), .fetch_valid(fv32), .annul_slot(an32),
    .link_addr(link32), .align_err(ae32)
  );

  pc_npc_sequencer #(.ADDR_W(8)) dut8 (
    .Clk(Clk), .R(R), .stall(stall), .xfer_valid(xfer_valid), .xfer_kind(xfer_kind),
    .cond_true(cond_true), .is_ba(is_ba), .annul_a(annul_a), .target(target[7:0]),
    .PC(pc8), .nPC(npc8), .fetch_valid(fv8), .annul_slot(an8),
    .link_addr(link8), .align_err(ae8)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_npc = 32'h4; m_link = 32'h0;
    m_run = 1'b0; m_annul = 1'b0; m_align = 1'b0;
  endtask

  // One clock of the architectural rules: delayed transfer, annul, link, alignment.
  task automatic model_step();
    logic        acc, tk, new_annul;
    logic [31:0] next_npc;
    if (!m_run) begin
      m_run = 1'b1;
      return;
    end
    if (stall) return;
    acc       = xfer_valid && (xfer_kind != 2'd3) && !m_annul;
    tk        = acc && ((xfer_kind != 2'd0) || is_ba || cond_true);
    next_npc  = m_npc + 32'd4;
    new_annul = acc && (xfer_kind == 2'd0) && annul_a && (is_ba || !cond_true);
    if (acc && xfer_kind != 2'd0) m_link = m_pc - 32'd4;
    if (tk) next_npc = target & ~32'd3;
`ifdef NPC_MISALIGN_TRAP_EN
    if (tk && target[1:0] != 2'b00) begin
      next_npc  = 32'h80;
      m_align   = 1'b1;
      new_annul = 1'b1;
    end
`endif
    m_pc    = m_npc;
    m_npc   = next_npc;
    m_annul = new_annul;
  endtask

  task automatic compare_all();
    check("pc32",   pc32,        m_pc);
    check("npc32",  npc32,       m_npc);
    check("link32", link32,      m_link);
    check("fv32",   32'(fv32),   32'(m_run));
    check("an32",   32'(an32),   32'(m_annul));
    check("ae32",   32'(ae32),   32'(m_align));
    check("pc8",    32'(pc8),    32'(m_pc[7:0]));
    check("npc8",   32'(npc8),   32'(m_npc[7:0]));
    check("link8",  32'(link8),  32'(m_link[7:0]));
    check("fv8",    32'(fv8),    32'(m_run));
    check("an8",    32'(an8),    32'(m_annul));
    check("ae8",    32'(ae8),    32'(m_align));
  endtask

  // Asynchronous reset mid-cycle: outputs must return to reset values before any edge.
  task automatic apply_reset();
    @(negedge Clk);
    R = 1'b0;
    #1;
    model_reset();
    check("rst_pc",   pc32,       32'h0);
    check("rst_npc",  npc32,      32'h4);
    check("rst_fv",   32'(fv32),  32'h0);
    check("rst_an",   32'(an32),  32'h0);
    check("rst_link", link32,     32'h0);
    check("rst_ae",   32'(ae32),  32'h0);
    compare_all();
    #1;
    R = 1'b1;
  endtask

  task automatic cycle(input logic st, input logic xv, input logic [1:0] kind, input logic ct,
                       input logic ba, input logic aa, input logic [31:0] tgt);
    stall = st; xfer_valid = xv; xfer_kind = kind;
    cond_true = ct; is_ba = ba; annul_a = aa; target = tgt;
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic reset_to_8();
    apply_reset();
    repeat (3) idle();
  endtask

  initial begin
    // Boot then sequential fetch.
    apply_reset();
    idle();
    check("t1_pc0", pc32, 32'h0);
    check("t1_fv",  32'(fv32), 32'h1);
    idle();
    idle();
    check("t1_pc8",  pc32,  32'h8);
    check("t1_npcC", npc32, 32'hC);

    // Conditional taken branch, no annul.
    cycle(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h40);
    check("t2_pc",  pc32,  32'hC);
    check("t2_npc", npc32, 32'h40);
    idle();
    check("t2_pc2", pc32,       32'h40);
    check("t2_an",  32'(an32),  32'h0);

    // Untaken annulled branch; a transfer in the annulled slot is ignored; then ba,a.
    reset_to_8();
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'h60);
    check("t3_an",  32'(an32), 32'h1);
    check("t3_pc",  pc32,      32'hC);
    cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h60);
    check("t3_ign_npc", npc32,     32'h14);
    check("t3_ign_an",  32'(an32), 32'h0);
    check("t3_ign_lnk", link32,    32'h0);
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h20);
    check("t3_ba_an", 32'(an32), 32'h1);
    idle();
    check("t3_ba_pc", pc32, 32'h20);

    // Call held by stall, accepted on release.
    reset_to_8();
    idle();
    idle();
    repeat (2) cycle(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h100);
    check("t4_hold_pc", pc32, 32'h10);
    cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h100);
    check("t4_link", link32, 32'hC);
    check("t4_pc",   pc32,   32'h14);
    check("t4_npc",  npc32,  32'h100);

    // Address wrap in both widths.
    reset_to_8();
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
    idle();
    idle();
    check("t5_pc32",  pc32,       32'hFFFF_FFFC);
    check("t5_npc32", npc32,      32'h0);
    check("t5_pc8",   32'(pc8),   32'hFC);
    check("t5_npc8",  32'(npc8),  32'h0);

    // Misaligned jmpl, then reset mid-sequence.
    reset_to_8();
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h42);
`ifdef NPC_MISALIGN_TRAP_EN
    check("t6_npc", npc32,     32'h80);
    check("t6_ae",  32'(ae32), 32'h1);
    check("t6_an",  32'(an32), 32'h1);
`else
    check("t6_npc", npc32,     32'h40);
    check("t6_ae",  32'(ae32), 32'h0);
`endif
    check("t6_link", link32, 32'h4);
    idle();
    apply_reset();

    // Transfer presented in BOOT is ignored.
    cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h40);
    check("boot_npc",  npc32,  32'h4);
    check("boot_link", link32, 32'h0);

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if ($urandom_range(0, 199) == 0) apply_reset();
      t = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
      cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
Parametrised PC/nPC pair with SPARC-style delayed control transfer, replacing the separate fixed 8-bit PC, nPC and +4 adder blocks.
- Sits at the IF stage and drives the instruction memory address.
- Accepts branch, call and jmpl redirects from ID, together with annul (bit 29) and condition results.
- Generates the delay-slot annul pulse, the link address for r15, and misalignment status.

Parameters:
ADDR_W, 32, PC/nPC/target width in bits (minimum 8)
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+4
TRAP_VECTOR, 'h80, redirect address on misaligned target (only used with the optional feature)

Ports:
Clk  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-low
stall  in  1  hold PC/nPC/state; a transfer presented during stall is ignored and must be held by ID
xfer_valid  in  1  control-transfer instruction in ID this cycle
xfer_kind  in  2  00 branch, 01 call, 10 jmpl, 11 reserved (treated as no transfer)
cond_true  in  1  branch condition evaluated true
is_ba  in  1  branch is unconditional "always"
annul_a  in  1  annul bit (instr[29])
target  in  ADDR_W  transfer destination
PC  out  ADDR_W  current fetch address
nPC  out  ADDR_W  next fetch address
fetch_valid  out  1  PC is a real fetch; low in BOOT
annul_slot  out  1  the delay-slot instruction must be converted to NOP
link_addr  out  ADDR_W  address of the last accepted call/jmpl, for the r15 write
align_err  out  1  sticky misaligned-target flag

Behaviour:
- Reset (R=0, asynchronous):
  - PC=RESET_PC, nPC=RESET_PC+4.
  - state=BOOT; fetch_valid=0, annul_slot=0, link_addr=0, align_err=0.
  - Reset asserted mid-operation discards any pending annul.
- FSM:
  - BOOT: one cycle. fetch_valid=0, no PC update. Next state RUN, regardless of stall.
  - RUN: fetch_valid=1.
  - When stall=1: PC, nPC, annul_slot, link_addr and state all hold.
- Accepted transfer: RUN & !stall & xfer_valid & xfer_kind!=11.
  - Taken: call, jmpl, or branch with (is_ba | cond_true).
- Update rule per non-stalled RUN cycle:
  - PC <= nPC.
  - nPC <= target if an accepted transfer is taken, else nPC+4.
  - Add is modulo 2^ADDR_W; 'hFFFFFFFC+4 wraps to 0.
  - Delay-slot semantics: the instruction at the old nPC always issues unless annulled.
- Annul:
  - annul_slot is registered and set on acceptance of a branch with annul_a=1 when either:
    - the branch is not taken, or
    - is_ba=1 (taken).
  - Conditional taken branches with a=1 do not annul.
  - call and jmpl never annul; annul_a is ignored for them.
  - annul_slot is high for exactly one non-stalled cycle and is held across stall cycles.
- Link address: on an accepted call/jmpl, link_addr <= PC-4 (address of the transfer instruction, modulo 2^ADDR_W). It holds otherwise.
- Alignment: target[1:0] is forced to 00 before loading into nPC.
- Simultaneous events:
  - stall and xfer_valid together: stall wins.
  - Transfer while annul_slot=1: the transfer is ignored. An annulled slot cannot redirect; nPC gets nPC+4.
  - Transfer in BOOT: ignored.

Optional Feature:
NPC_MISALIGN_TRAP_EN.
- Defined:
  - An accepted taken transfer with target[1:0]!=0 loads nPC <= TRAP_VECTOR.
  - align_err is set (sticky until reset).
  - annul_slot is set.
- Undefined:
  - Low bits are cleared silently.
  - align_err is tied 0.
  - TRAP_VECTOR is unused.

Test Plan:
1. Reset with RESET_PC=0, release R, 3 clocks, no stall -> cycle0 BOOT fetch_valid=0 PC=0; then PC=0,4,8 with nPC=4,8,12.
2. PC=8,nPC=12: accept branch, cond_true=1, annul_a=0, target='h40 -> next PC=12, nPC='h40; following PC='h40, nPC='h44; annul_slot stays 0.
3. PC=8: branch cond_true=0, annul_a=1 -> annul_slot=1 for one cycle with PC=12; then PC=16. Repeat with is_ba=1, target='h20 -> annul_slot=1, PC reaches 'h20.
4. PC='h10: call target='h100 with stall=1 for 2 cycles, then stall=0 -> PC/nPC frozen during stall; on release link_addr='hC, PC='h14, nPC='h100.
5. ADDR_W=8, PC='hF8, nPC='hFC, no transfer -> PC='hFC, nPC='h00 (wrap).
6. jmpl target='h42: with NPC_MISALIGN_TRAP_EN -> nPC='h80, align_err=1, annul_slot=1; without -> nPC='h40, align_err=0. Assert R mid-sequence -> all outputs return to reset values immediately.
